// File: rtl/mac_unit.sv
// mac_unit: sequential signed multiply-accumulate.
// A request accepted in IDLE computes acc_in + a*b. The product comes from a
// radix-2 shift-add loop over DATA_WIDTH cycles on operand magnitudes, and the
// sign is re-applied at the end. The result is returned with a one-cycle
// mac_valid pulse, together with an optional saturating accumulate and an
// overflow flag.
//
// Handshake: mac_start is a request strobe that is looked at only while the
// unit is idle (busy=0). The accepting edge captures mac_a/mac_b/mac_acc_in,
// so they may change afterwards. busy stays high until the result edge. At
// that edge mac_valid pulses for exactly one cycle and mac_acc_out/overflow
// update and then hold. There is no back-pressure: the consumer must take the
// result in the mac_valid cycle. A mac_start seen while busy is dropped.
module mac_unit #(
  parameter int DATA_WIDTH = 16,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mac_start,
  input  logic [DATA_WIDTH-1:0]     mac_a,
  input  logic [DATA_WIDTH-1:0]     mac_b,
  input  logic [2*DATA_WIDTH-1:0]   mac_acc_in,
  output logic [2*DATA_WIDTH-1:0]   mac_acc_out,
  output logic                      mac_valid,
  output logic                      busy,
  output logic                      overflow
);

  localparam int AW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [DATA_WIDTH-1:0] a_abs_q, a_abs_d;
  logic [DATA_WIDTH-1:0] b_sh_q, b_sh_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [AW-1:0]         pp_q, pp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         acc_out_q, acc_out_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;

  // Datapath helpers
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [AW-1:0]         a_shifted;
  logic [AW-1:0]         product;
  logic [AW:0]           sum;
  logic                  sum_ovf;
  logic [AW-1:0]         sat_val;

  // Magnitudes of the incoming operands; -2^(DW-1) maps to 2^(DW-1) unsigned
  assign a_mag     = mac_a[DATA_WIDTH-1] ? -mac_a : mac_a;
  assign b_mag     = mac_b[DATA_WIDTH-1] ? -mac_b : mac_b;
  assign a_shifted = {{DATA_WIDTH{1'b0}}, a_abs_q} << cnt_q;
  // Product magnitude is at most 2^(AW-2), so negation cannot overflow
  assign product   = sign_q ? -pp_q : pp_q;
  assign sum       = {acc_q[AW-1], acc_q} + {product[AW-1], product};
  assign sum_ovf   = (acc_q[AW-1] == product[AW-1]) && (sum[AW-1] != acc_q[AW-1]);
  // Clamp direction follows the operand sign (both operands share it on overflow)
  assign sat_val   = acc_q[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};

  // Next-state and datapath updates for the IDLE/MUL/ACC sequence
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    a_abs_d   = a_abs_q;
    b_sh_d    = b_sh_q;
    acc_d     = acc_q;
    pp_d      = pp_q;
    cnt_d     = cnt_q;
    acc_out_d = acc_out_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (mac_start) begin
          sign_d  = mac_a[DATA_WIDTH-1] ^ mac_b[DATA_WIDTH-1];
          a_abs_d = a_mag;
          b_sh_d  = b_mag;
          acc_d   = mac_acc_in;
          pp_d    = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (b_sh_q[0]) pp_d = pp_q + a_shifted;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_WIDTH - 1)) state_d = ACC;
      end
      ACC: begin
        ovf_d     = sum_ovf;
        acc_out_d = (SATURATE && sum_ovf) ? sat_val : sum[AW-1:0];
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      a_abs_q   <= '0;
      b_sh_q    <= '0;
      acc_q     <= '0;
      pp_q      <= '0;
      cnt_q     <= '0;
      acc_out_q <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      a_abs_q   <= a_abs_d;
      b_sh_q    <= b_sh_d;
      acc_q     <= acc_d;
      pp_q      <= pp_d;
      cnt_q     <= cnt_d;
      acc_out_q <= acc_out_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign mac_acc_out = acc_out_q;
  assign mac_valid   = valid_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q != IDLE);

endmodule
